// File: rtl/debug_sender.sv
// Streams a debug snapshot (PC, cycle count, register file, data memory) out of a
// byte-wide UART, each word least-significant byte first, one byte per tx_done handshake.
module debug_sender #(
    parameter int LEN_DATA = 8,
    parameter int LEN      = 32,
    parameter int N_REGS   = 32,
    parameter int N_MEM    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN-1:0]      pc_in,
    input  logic [LEN-1:0]      cycles_in,
    output logic [4:0]          reg_addr,
    input  logic [LEN-1:0]      reg_data,
    output logic [7:0]          mem_addr,
    input  logic [LEN-1:0]      mem_data,
    input  logic                tx_done,
    output logic                tx_start,
    output logic [LEN_DATA-1:0] tx_data,
    output logic                busy,
    output logic                done
);
    localparam int W      = 2 + N_REGS + N_MEM;
    localparam int WIDX_W = $clog2(W);
    localparam logic [WIDX_W-1:0] REG_LO  = WIDX_W'(2);
    localparam logic [WIDX_W-1:0] REG_END = WIDX_W'(2 + N_REGS);
    localparam logic [WIDX_W-1:0] LAST    = WIDX_W'(W - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LATCH, SEND, WAIT} state_t;

    state_t            state_q, state_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [LEN-1:0]    shift_q, shift_d;
    logic [LEN-1:0]    pc_sh_q, pc_sh_d;
    logic [LEN-1:0]    cyc_sh_q, cyc_sh_d;
    logic              done_q, done_d;
    logic              in_reg, in_mem;

    // Read addresses follow word_idx directly so a synchronous source has the ADDR cycle to respond.
    always_comb begin
        in_reg   = (word_idx_q >= REG_LO) && (word_idx_q < REG_END);
        in_mem   = (word_idx_q >= REG_END);
        reg_addr = in_reg ? 5'(word_idx_q - REG_LO) : 5'd0;
        mem_addr = in_mem ? 8'(word_idx_q - REG_END) : 8'd0;
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pc_sh_d    = pc_sh_q;
        cyc_sh_d   = cyc_sh_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_sh_d    = pc_in;
                    cyc_sh_d   = cycles_in;
                    word_idx_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR:  state_d = LATCH;
            LATCH: begin
                if (word_idx_q == '0)               shift_d = pc_sh_q;
                else if (word_idx_q == WIDX_W'(1))  shift_d = cyc_sh_q;
                else if (in_reg)                    shift_d = reg_data;
                else                                shift_d = mem_data;
                byte_idx_d = 2'd0;
                state_d    = SEND;
            end
            SEND:  state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q != 2'd3) begin
                        shift_d    = shift_q >> LEN_DATA;
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = SEND;
                    end else if (word_idx_q != LAST) begin
                        word_idx_d = word_idx_q + WIDX_W'(1);
                        state_d    = ADDR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            pc_sh_q    <= '0;
            cyc_sh_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            pc_sh_q    <= pc_sh_d;
            cyc_sh_q   <= cyc_sh_d;
            done_q     <= done_d;
        end
    end

    assign tx_start = (state_q == SEND);
    assign tx_data  = shift_q[LEN_DATA-1:0];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_debug_sender.sv
// Bench for debug_sender: UART responder, synchronous-read memories, and a byte-stream model.
module tb_debug_sender;
    localparam int NR = 4;
    localparam int NM = 2;
    localparam int NW = 2 + NR + NM;
    localparam int NB = 4 * NW;

    logic        clk = 1'b0;
    logic        reset, start, tx_done;
    logic [31:0] pc_in, cycles_in, reg_data, mem_data;
    logic [4:0]  reg_addr;
    logic [7:0]  mem_addr;
    logic        tx_start, busy, done;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    debug_sender #(.LEN_DATA(8), .LEN(32), .N_REGS(NR), .N_MEM(NM)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .cycles_in(cycles_in),
        .reg_addr(reg_addr), .reg_data(reg_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference contents and expected byte stream
    logic [31:0] regs [32];
    logic [31:0] mem  [256];
    logic [31:0] pc_snap, cyc_snap;
    logic [7:0]  exp_q [$];

    function automatic void build_expected();
        logic [31:0] word;
        exp_q.delete();
        for (int w = 0; w < NW; w++) begin
            if (w == 0)           word = pc_snap;
            else if (w == 1)      word = cyc_snap;
            else if (w < 2 + NR)  word = regs[w - 2];
            else                  word = mem[w - 2 - NR];
            for (int b = 0; b < 4; b++) exp_q.push_back(word[8*b +: 8]);
        end
    endfunction

    // UART responder and synchronous-read register file / data memory
    int   dly = 5;
    bit   rnd_dly = 0;
    bit   inj_send = 0;
    initial begin
        int cnt;
        logic [4:0] ra_prev;
        logic [7:0] ma_prev;
        cnt = 0; ra_prev = '0; ma_prev = '0;
        tx_done = 1'b0; reg_data = '0; mem_data = '0;
        forever begin
            @(posedge clk); #1;
            reg_data = regs[ra_prev];
            mem_data = mem[ma_prev];
            ra_prev  = reg_addr;
            ma_prev  = mem_addr;
            tx_done  = 1'b0;
            if (!busy) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_done = 1'b1;
                end
                if (tx_start) begin
                    cnt = rnd_dly ? int'($urandom_range(1, 6)) : dly;
                    if (inj_send) tx_done = 1'b1;
                end
            end
        end
    end

    // Monitor: collects bytes and checks handshake timing
    int          nbytes = 0, done_cnt = 0, start_cyc = 0, last_done_cyc = 0;
    bit          awaiting = 0;
    logic [7:0]  got_q [$];
    initial begin
        int exp_cyc;
        forever begin
            @(negedge clk);
            if (!reset && start && !busy) begin
                got_q.delete();
                nbytes = 0; done_cnt = 0; start_cyc = cyc; awaiting = 0;
            end
            if (!reset && busy) begin
                if (tx_start) begin
                    if (nbytes == 0)          exp_cyc = start_cyc + 3;
                    else if (nbytes % 4 != 0) exp_cyc = last_done_cyc + 1;
                    else                      exp_cyc = last_done_cyc + 3;
                    chk("tx_start_timing", cyc, exp_cyc);
                    got_q.push_back(tx_data);
                    nbytes++;
                    awaiting = 1;
                end else if (awaiting) begin
                    chk("tx_data_hold", 32'(tx_data), 32'(got_q[$]));
                    if (tx_done) begin
                        last_done_cyc = cyc;
                        awaiting = 0;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_timing", cyc, last_done_cyc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_dump(input int stop_after, input bit stray, input bit scramble);
        logic ptx;
        bit   finished;
        pc_snap  = pc_in;
        cyc_snap = cycles_in;
        build_expected();
        finished = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            pc_in     = 32'hFFFF_FFFF;
            cycles_in = $urandom;
        end
        for (int k = 0; k < 3000; k++) begin
            ptx = tx_start;
            tick();
            start = stray && ptx;
            if (stop_after > 0 && nbytes == stop_after) begin
                finished = 1;
                break;
            end
            if (done_cnt > 0) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) chk("dump_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_dump(input string tag);
        repeat (12) tick();
        chk({tag, "_byte_count"}, 32'(got_q.size()), 32'(NB));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pc_in = '0; cycles_in = '0;
        for (int i = 0; i < 32; i++)  regs[i] = $urandom;
        for (int i = 0; i < 256; i++) mem[i]  = $urandom;
        repeat (3) tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Known pattern, fixed 5-cycle UART
        regs[0] = 32'h1122_3344; regs[1] = 32'h5566_7788;
        regs[2] = 32'h99AA_BBCC; regs[3] = 32'hDDEE_FF00;
        mem[0]  = 32'hCAFE_F00D; mem[1]  = 32'h0BAD_BEEF;
        pc_in = 32'h0000_0010; cycles_in = 32'h0000_0007;
        dly = 5;
        run_dump(0, 0, 0);
        check_dump("basic");

        // PC / cycle snapshot survives input changes, random UART latency
        pc_in = 32'h0000_0010; cycles_in = $urandom;
        rnd_dly = 1;
        run_dump(0, 0, 1);
        check_dump("snapshot");

        // Stray start during WAIT and tx_done during SEND
        pc_in = $urandom; cycles_in = $urandom;
        inj_send = 1;
        run_dump(0, 1, 0);
        inj_send = 0;
        check_dump("stray");

        // Reset mid-dump after 13 bytes, then a clean restart
        pc_in = $urandom; cycles_in = $urandom;
        run_dump(13, 0, 0);
        chk("mid_byte_count", 32'(nbytes), 32'd13);
        reset = 1'b1;
        tick();
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_busy",     32'(busy),     32'd0);
        chk("mid_rst_tx_data",  32'(tx_data),  32'd0);
        chk("mid_rst_done",     32'(done),     32'd0);
        reset = 1'b0;
        repeat (3) tick();
        run_dump(0, 0, 0);
        check_dump("restart");

        // Reset and start together in IDLE
        reset = 1'b1; start = 1'b1;
        tick();
        chk("rst_start_busy0", 32'(busy), 32'd0);
        tick();
        chk("rst_start_busy1", 32'(busy), 32'd0);
        chk("rst_start_txs",   32'(tx_start), 32'd0);
        reset = 1'b0; start = 1'b0;
        repeat (4) tick();
        chk("rst_start_idle", 32'(busy), 32'd0);

        // Randomized dumps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
            for (int i = 0; i < NM; i++) mem[i]  = $urandom;
            pc_in = $urandom; cycles_in = $urandom;
            inj_send = ($urandom_range(0, 1) == 1);
            run_dump(0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
            inj_send = 0;
            check_dump($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
